// File: rtl/regfile_scrub_ctrl_if.sv
// Register-file side bundle of the scrubber: WB write request in, RF write port and scrub read port out.
// Ports: wb_we/wb_addr/wb_data (WB-stage write), rf_we/rf_waddr/rf_wdata (RF write port),
//        rf_saddr/rf_scode (scrub read address and the raw 39-bit codeword returned by the RF).
interface regfile_scrub_ctrl_if;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_saddr;
    logic [38:0] rf_scode;

    // master: the scrub controller
    modport master (
        input  wb_we, wb_addr, wb_data, rf_scode,
        output rf_we, rf_waddr, rf_wdata, rf_saddr
    );

    // slave: the pipeline WB stage plus register file
    modport slave (
        output wb_we, wb_addr, wb_data, rf_scode,
        input  rf_we, rf_waddr, rf_wdata, rf_saddr
    );
endinterface

// File: rtl/regfile_scrub_ctrl.sv
// Background SECDED scrubber for x1..x31 plus WB/scrub arbiter on the register file write port.
// Latency: READ->CHECK->WRITE is 3 cycles for a correction, READ->CHECK 2 cycles for a clean/uncorrectable check.
// Backpressure: WB writes always win the write port; a pending scrub write waits in WRITE until wb_we drops.
// Ports: clk, rst (async active-low), scrub_en, err_clr, bus (regfile_scrub_ctrl_if.master),
//        busy, corr_cnt, uncorr_cnt, err_flag, err_addr.
module regfile_scrub_ctrl #(
    parameter int SCRUB_INTERVAL = 256,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scrub_en,
    input  logic                        err_clr,
    regfile_scrub_ctrl_if.master        bus,
    output logic                        busy,
    output logic [CNT_W-1:0]            corr_cnt,
    output logic [CNT_W-1:0]            uncorr_cnt,
    output logic                        err_flag,
    output logic [4:0]                  err_addr
);

    localparam int              IW       = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [IW-1:0]   INT_LAST = IW'(SCRUB_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE
    } state_t;

    state_t         state_q;
    logic [4:0]     ptr_q;
    logic [IW-1:0]  icnt_q;
    logic [4:0]     saddr_q;
    logic [38:0]    code_q;
    logic           stale_q;

    // Hamming position of data bit idx: the idx-th non-power-of-2 position starting at 3.
    function automatic logic [5:0] data_pos(input int idx);
        logic [5:0] pos;
        int         n;
        pos = 6'd0;
        n   = 0;
        for (int p = 3; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) pos = 6'(p);
                n++;
            end
        end
        return pos;
    endfunction

    // Decode of the registered codeword. XOR-ing the positions of all set data bits
    // gives the recomputed check vector directly; folding in the stored checks yields s.
    logic [5:0]  syn;
    logic        par;
    logic [31:0] fix_data;

    always_comb begin
        syn      = code_q[37:32];
        fix_data = code_q[31:0];
        for (int j = 0; j < 32; j++) begin
            if (code_q[j]) syn = syn ^ data_pos(j);
        end
        par = ^code_q;
        // s pointing at a check/parity position (0 or power of 2) matches no data bit,
        // so the data passes through unchanged in that case.
        for (int j = 0; j < 32; j++) begin
            if (par && (syn == data_pos(j))) fix_data[j] = ~code_q[j];
        end
    end

    // A WB write to the register under scrub makes the sampled codeword obsolete.
    logic       collide;
    logic [4:0] ptr_adv;
    logic       go_idle;

    assign collide = bus.wb_we && (bus.wb_addr == ptr_q);
    assign ptr_adv = (ptr_q == 5'd31) ? 5'd1 : ptr_q + 5'd1;

    always_comb begin
        go_idle = 1'b0;
        case (state_q)
            S_CHECK: go_idle = stale_q || collide || !par;
            S_WRITE: go_idle = !bus.wb_we || collide;
            default: go_idle = 1'b0;
        endcase
    end

    // Write port mux: WB first, then the scrub write-back.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = 5'd0;
        bus.rf_wdata = 32'd0;
        if (bus.wb_we) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.wb_addr;
            bus.rf_wdata = bus.wb_data;
        end else if (state_q == S_WRITE) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = ptr_q;
            bus.rf_wdata = fix_data;
        end
    end

    assign bus.rf_saddr = saddr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            busy       <= 1'b0;
            ptr_q      <= 5'd1;
            icnt_q     <= '0;
            saddr_q    <= 5'd0;
            code_q     <= '0;
            stale_q    <= 1'b0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            err_flag   <= 1'b0;
            err_addr   <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (scrub_en) begin
                        if (icnt_q == INT_LAST) begin
                            icnt_q  <= '0;
                            saddr_q <= ptr_q;
                            state_q <= S_READ;
                            busy    <= 1'b1;
                        end else begin
                            icnt_q <= icnt_q + IW'(1);
                        end
                    end
                end
                S_READ: begin
                    code_q  <= bus.rf_scode;
                    stale_q <= collide;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (!(stale_q || collide)) begin
                        if (par) begin
                            if (corr_cnt != CNT_MAX) corr_cnt <= corr_cnt + CNT_ONE;
                            state_q <= S_WRITE;
                        end else if (syn != 6'd0) begin
                            if (uncorr_cnt != CNT_MAX) uncorr_cnt <= uncorr_cnt + CNT_ONE;
                            if (!err_flag) err_addr <= ptr_q;
                            err_flag <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // Exit is handled by go_idle; staying here just waits for the port.
                end
                default: state_q <= S_IDLE;
            endcase

            if (go_idle) begin
                state_q <= S_IDLE;
                busy    <= 1'b0;
                ptr_q   <= ptr_adv;
            end

            // Clear overrides any same-cycle increment or flag set.
            if (err_clr) begin
                corr_cnt   <= '0;
                uncorr_cnt <= '0;
                err_flag   <= 1'b0;
                err_addr   <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scrub_ctrl.sv
// Self-checking bench: directed scenarios plus randomized WB traffic and error injection,
// compared every cycle against a model that knows which bits were flipped in each register.
module tb_regfile_scrub_ctrl;

    localparam int SI   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int P_IDLE  = 0;
    localparam int P_READ  = 1;
    localparam int P_CHECK = 2;
    localparam int P_WRITE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          scrub_en;
    logic          err_clr;
    logic          busy;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;
    logic          err_flag;
    logic [4:0]    err_addr;

    regfile_scrub_ctrl_if bus();

    regfile_scrub_ctrl #(.SCRUB_INTERVAL(SI), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .scrub_en   (scrub_en),
        .err_clr    (err_clr),
        .bus        (bus),
        .busy       (busy),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .err_flag   (err_flag),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    // Register file model: true data plus the bits flipped on top of a clean encoding.
    logic [31:0] rf_true [32];
    logic [38:0] flip    [32];

    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [38:0] cw;
        logic [38:0] h;
        int          k;
        h = '0;
        k = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                h[pos] = d[k];
                k++;
            end
        end
        cw[31:0] = d;
        for (int i = 0; i < 6; i++) begin
            cw[32+i] = 1'b0;
            for (int pos = 1; pos <= 38; pos++) begin
                if (((pos >> i) & 1) == 1 && (pos & (pos - 1)) != 0) cw[32+i] = cw[32+i] ^ h[pos];
            end
        end
        cw[38] = ^cw[37:0];
        return cw;
    endfunction

    assign bus.rf_scode = enc(rf_true[bus.rf_saddr]) ^ flip[bus.rf_saddr];

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int          m_phase;
    int          m_cnt;
    logic [4:0]  m_ptr;
    logic [4:0]  m_saddr;
    logic        m_stale;
    int          m_nerr;
    logic [31:0] m_data;
    int          m_corr;
    int          m_uncorr;
    logic        m_flag;
    logic [4:0]  m_addr;

    logic        pw_vld;
    logic [4:0]  pw_addr;
    logic [31:0] pw_data;
    int          sw_cnt;

    task automatic chk(input string name, input logic [38:0] act, input logic [38:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase  = P_IDLE;
        m_cnt    = 0;
        m_ptr    = 5'd1;
        m_saddr  = 5'd0;
        m_stale  = 1'b0;
        m_nerr   = 0;
        m_data   = 32'd0;
        m_corr   = 0;
        m_uncorr = 0;
        m_flag   = 1'b0;
        m_addr   = 5'd0;
        pw_vld   = 1'b0;
    endtask

    task automatic m_done();
        m_phase = P_IDLE;
        m_ptr   = (m_ptr == 5'd31) ? 5'd1 : m_ptr + 5'd1;
    endtask

    task automatic compare();
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        e_we = 1'b0; e_waddr = 5'd0; e_wdata = 32'd0;
        if (bus.wb_we) begin
            e_we = 1'b1; e_waddr = bus.wb_addr; e_wdata = bus.wb_data;
        end else if (m_phase == P_WRITE) begin
            e_we = 1'b1; e_waddr = m_ptr; e_wdata = m_data;
        end
        chk("rf_we",      39'(bus.rf_we),    39'(e_we));
        chk("rf_waddr",   39'(bus.rf_waddr), 39'(e_waddr));
        chk("rf_wdata",   39'(bus.rf_wdata), 39'(e_wdata));
        chk("rf_saddr",   39'(bus.rf_saddr), 39'(m_saddr));
        chk("busy",       39'(busy),         39'(m_phase != P_IDLE));
        chk("corr_cnt",   39'(corr_cnt),     39'(m_corr));
        chk("uncorr_cnt", 39'(uncorr_cnt),   39'(m_uncorr));
        chk("err_flag",   39'(err_flag),     39'(m_flag));
        chk("err_addr",   39'(err_addr),     39'(m_addr));
    endtask

    task automatic model_step();
        logic coll;
        coll = bus.wb_we && (bus.wb_addr == m_ptr);
        case (m_phase)
            P_IDLE: begin
                if (scrub_en) begin
                    if (m_cnt == SI - 1) begin
                        m_cnt = 0; m_phase = P_READ; m_saddr = m_ptr;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            P_READ: begin
                m_stale = coll;
                m_data  = rf_true[m_ptr];
                m_nerr  = $countones(flip[m_ptr]);
                m_phase = P_CHECK;
            end
            P_CHECK: begin
                if (m_stale || coll || m_nerr == 0) begin
                    m_done();
                end else if (m_nerr == 1) begin
                    if (m_corr < CMAX) m_corr++;
                    m_phase = P_WRITE;
                end else begin
                    if (m_uncorr < CMAX) m_uncorr++;
                    if (!m_flag) m_addr = m_ptr;
                    m_flag = 1'b1;
                    m_done();
                end
            end
            default: begin
                if (!bus.wb_we || coll) m_done();
            end
        endcase
        if (err_clr) begin
            m_corr = 0; m_uncorr = 0; m_flag = 1'b0; m_addr = 5'd0;
        end
    endtask

    // One clock: compare, advance the model, then let the RF absorb this cycle's write.
    task automatic tick();
        #1;
        compare();
        if (bus.rf_we && !bus.wb_we) sw_cnt++;
        model_step();
        pw_vld  = bus.rf_we;
        pw_addr = bus.rf_waddr;
        pw_data = bus.rf_wdata;
        @(negedge clk);
        if (pw_vld) begin
            rf_true[pw_addr] = pw_data;
            flip[pw_addr]    = '0;
        end
    endtask

    task automatic reset_vals_check();
        chk("rst_busy",     39'(busy),         39'(0));
        chk("rst_rf_we",    39'(bus.rf_we),    39'(0));
        chk("rst_rf_saddr", 39'(bus.rf_saddr), 39'(0));
        chk("rst_corr",     39'(corr_cnt),     39'(0));
        chk("rst_uncorr",   39'(uncorr_cnt),   39'(0));
        chk("rst_err_flag", 39'(err_flag),     39'(0));
        chk("rst_err_addr", 39'(err_addr),     39'(0));
    endtask

    task automatic do_reset();
        bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
        scrub_en = 1'b0; err_clr = 1'b0;
        #2 rst = 1'b0;
        #1 reset_vals_check();
        m_reset();
        sw_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 32; r++) flip[r] = '0;
    endtask

    task automatic run_until(input int ph, input logic [4:0] p, input int max, input string name);
        int n;
        n = 0;
        while (!(m_phase == ph && m_ptr == p) && n < max) begin
            tick();
            n++;
        end
        total++;
        if (!(m_phase == ph && m_ptr == p)) begin
            bad++;
            $display("FAIL %s: scrub of x%0d not reached within %0d cycles", name, p, max);
        end
    endtask

    initial begin
        rst = 1'b0;
        scrub_en = 1'b0; err_clr = 1'b0;
        bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
        for (int r = 0; r < 32; r++) begin
            rf_true[r] = 32'hA500_0000 | 32'(r);
            flip[r]    = '0;
        end
        m_reset();
        sw_cnt = 0;
        @(negedge clk);

        // clean walk: one register every 6 cycles, no writes, no counts
        do_reset();
        scrub_en = 1'b1;
        for (int k = 1; k <= 190; k++) begin
            tick();
            if (k == 4)   chk("walk_first",  39'(bus.rf_saddr), 39'(1));
            if (k == 10)  chk("walk_second", 39'(bus.rf_saddr), 39'(2));
            if (k == 184) chk("walk_x31",    39'(bus.rf_saddr), 39'(31));
            if (k == 190) chk("walk_wrap",   39'(bus.rf_saddr), 39'(1));
        end
        chk("walk_no_write", 39'(sw_cnt),   39'(0));
        chk("walk_corr",     39'(corr_cnt), 39'(0));

        // x5 data bit 0 flipped -> rewrite with original value
        do_reset();
        rf_true[5] = 32'h1234_5678;
        flip[5]    = 39'd1;
        scrub_en   = 1'b1;
        run_until(P_WRITE, 5'd5, 200, "reach_x5");
        #1;
        chk("x5_we",    39'(bus.rf_we),    39'(1));
        chk("x5_waddr", 39'(bus.rf_waddr), 39'(5));
        chk("x5_wdata", 39'(bus.rf_wdata), 39'(32'h1234_5678));
        chk("x5_corr",  39'(corr_cnt),     39'(1));
        tick();

        // x7 check bit c2 flipped (data unchanged); x9 double error
        do_reset();
        rf_true[7] = 32'h0BAD_F00D;
        flip[7]    = 39'd1 << 34;
        flip[9]    = 39'd3;
        scrub_en   = 1'b1;
        run_until(P_WRITE, 5'd7, 200, "reach_x7");
        #1;
        chk("x7_waddr", 39'(bus.rf_waddr), 39'(7));
        chk("x7_wdata", 39'(bus.rf_wdata), 39'(32'h0BAD_F00D));
        chk("x7_corr",  39'(corr_cnt),     39'(1));
        run_until(P_IDLE, 5'd10, 60, "reach_x10");
        chk("x9_uncorr", 39'(uncorr_cnt), 39'(1));
        chk("x9_flag",   39'(err_flag),   39'(1));
        chk("x9_addr",   39'(err_addr),   39'(9));
        chk("x9_nowr",   39'(sw_cnt),     39'(1));

        // x3 overall-parity error; correction held off by 3 WB writes to x10
        do_reset();
        rf_true[3] = 32'h3333_CAFE;
        flip[3]    = 39'd1 << 38;
        scrub_en   = 1'b1;
        run_until(P_WRITE, 5'd3, 200, "reach_x3");
        for (int k = 0; k < 3; k++) begin
            bus.wb_we = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'h0A0A_0000 + 32'(k);
            #1;
            chk("hold_waddr", 39'(bus.rf_waddr), 39'(10));
            chk("hold_wdata", 39'(bus.rf_wdata), 39'(32'h0A0A_0000 + 32'(k)));
            tick();
        end
        bus.wb_we = 1'b0;
        #1;
        chk("x3_we",    39'(bus.rf_we),    39'(1));
        chk("x3_waddr", 39'(bus.rf_waddr), 39'(3));
        chk("x3_wdata", 39'(bus.rf_wdata), 39'(32'h3333_CAFE));
        tick();
        chk("x3_idle", 39'(busy), 39'(0));

        // x12 single error made stale by a WB write during CHECK
        do_reset();
        flip[12] = 39'd1 << 20;
        scrub_en = 1'b1;
        run_until(P_CHECK, 5'd12, 200, "reach_x12");
        bus.wb_we = 1'b1; bus.wb_addr = 5'd12; bus.wb_data = 32'h0000_1212;
        tick();
        bus.wb_we = 1'b0;
        chk("x12_corr", 39'(corr_cnt), 39'(0));
        run_until(P_READ, 5'd13, 20, "reach_x13");
        chk("x13_saddr", 39'(bus.rf_saddr), 39'(13));
        chk("x12_nowr",  39'(sw_cnt),       39'(0));

        // asynchronous reset in the middle of WRITE
        do_reset();
        flip[1]  = 39'd1 << 3;
        scrub_en = 1'b1;
        run_until(P_WRITE, 5'd1, 200, "reach_x1");
        #1 chk("pre_rst_busy", 39'(busy), 39'(1));
        #1 rst = 1'b0;
        #1;
        chk("async_busy",  39'(busy),      39'(0));
        chk("async_rf_we", 39'(bus.rf_we), 39'(0));
        m_reset();
        @(negedge clk);
        rst = 1'b1;

        // saturation over a full pass, then clear
        do_reset();
        for (int r = 1; r < 32; r++) flip[r] = (r % 4 == 0) ? (39'd3 << r) : (39'd1 << r);
        scrub_en = 1'b1;
        for (int k = 0; k < 215; k++) tick();
        chk("sat_corr",   39'(corr_cnt),   39'(CMAX));
        chk("sat_uncorr", 39'(uncorr_cnt), 39'(7));
        chk("sat_addr",   39'(err_addr),   39'(4));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_corr",   39'(corr_cnt),   39'(0));
        chk("clr_uncorr", 39'(uncorr_cnt), 39'(0));
        chk("clr_flag",   39'(err_flag),   39'(0));
        chk("clr_addr",   39'(err_addr),   39'(0));

        // randomized traffic and injection
        do_reset();
        for (int r = 0; r < 32; r++) rf_true[r] = $urandom;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 6) begin
                int r;
                int b1;
                int b2;
                r = $urandom_range(1, 31);
                if (flip[r] == '0) begin
                    b1 = $urandom_range(0, 38);
                    flip[r][b1] = 1'b1;
                    if ($urandom_range(0, 2) == 0) begin
                        b2 = (b1 + $urandom_range(1, 38)) % 39;
                        flip[r][b2] = 1'b1;
                    end
                end
            end
            bus.wb_we   = ($urandom_range(0, 99) < 35);
            bus.wb_addr = ($urandom_range(0, 3) == 0) ? m_ptr : 5'($urandom_range(0, 31));
            bus.wb_data = $urandom;
            scrub_en    = ($urandom_range(0, 99) < 92);
            err_clr     = ($urandom_range(0, 99) < 2);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
